// File: rtl/ace_pkg.sv
// ACE snoop-channel types shared by the CCU snoop arbiter and its ownership FIFOs.
package ace_pkg;

  localparam int unsigned AddrWidth     = 32;
  localparam int unsigned DataWidth     = 64;
  localparam int unsigned MaskWidth     = 4;
  localparam int unsigned NumSnoopReq   = 2;
  localparam int unsigned OwnerIdxWidth = (NumSnoopReq > 1) ? $clog2(NumSnoopReq) : 1;

  typedef logic [3:0]               acsnoop_t;
  typedef logic [2:0]               acprot_t;
  typedef logic [OwnerIdxWidth-1:0] owner_idx_t;
  typedef logic [MaskWidth-1:0]     ace_domain_mask_t;

  typedef struct packed {
    logic WasUnique;
    logic IsShared;
    logic PassDirty;
    logic Error;
    logic DataTransfer;
  } crresp_t;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    acsnoop_t             snoop;
    acprot_t              prot;
  } ace_ac_t;

  typedef crresp_t ace_cr_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic                 last;
  } ace_cd_t;

  typedef struct packed {
    logic    ac_valid;
    ace_ac_t ac;
    logic    cr_ready;
    logic    cd_ready;
  } ace_snoop_req_t;

  typedef struct packed {
    logic    ac_ready;
    logic    cr_valid;
    ace_cr_t cr_resp;
    logic    cd_valid;
    ace_cd_t cd;
  } ace_snoop_resp_t;

endpackage

// File: rtl/ccu_snoop_arbiter_owner_fifo.sv
// ccu_snoop_owner_fifo: synchronous FIFO of requester indices; full/empty reflect registered occupancy.
module ccu_snoop_owner_fifo #(
  parameter int unsigned Depth  = 4,
  parameter type         data_t = logic
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  push_i,
  input  data_t data_i,
  input  logic  pop_i,
  output data_t data_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  data_t           r_mem [Depth];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [CntW-1:0] r_cnt;
  logic            w_push;
  logic            w_pop;

  assign full_o  = (r_cnt == CntW'(Depth));
  assign empty_o = (r_cnt == '0);
  assign data_o  = r_mem[r_rptr];
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= data_i;
  end

  // Simultaneous push and pop leaves occupancy unchanged
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == PtrW'(Depth - 1)) ? '0 : r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= (r_rptr == PtrW'(Depth - 1)) ? '0 : r_rptr + PtrW'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + CntW'(1);
      else if (w_pop && !w_push) r_cnt <= r_cnt - CntW'(1);
    end
  end

endmodule

// File: rtl/ccu_snoop_arbiter.sv
// Arbitrates requester AC snoops onto one crossbar port and routes CR/CD back by ownership order.
// Define CCU_SNOOP_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module ccu_snoop_arbiter
  import ace_pkg::*;
#(
  parameter int unsigned NumReq           = 2,
  parameter int unsigned OwnerDepth       = 4,
  parameter type         ac_chan_t        = ace_ac_t,
  parameter type         cr_chan_t        = ace_cr_t,
  parameter type         cd_chan_t        = ace_cd_t,
  parameter type         mst_snoop_req_t  = ace_snoop_req_t,
  parameter type         mst_snoop_resp_t = ace_snoop_resp_t,
  parameter type         domain_mask_t    = ace_domain_mask_t
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumReq-1:0] req_ac_valid_i,
  input  ac_chan_t          req_ac_i [NumReq],
  output logic [NumReq-1:0] req_ac_ready_o,
  input  domain_mask_t      req_mask_i [NumReq],
  output logic [NumReq-1:0] req_cr_valid_o,
  input  logic [NumReq-1:0] req_cr_ready_i,
  output cr_chan_t          req_cr_o,
  output logic [NumReq-1:0] req_cd_valid_o,
  input  logic [NumReq-1:0] req_cd_ready_i,
  output cd_chan_t          req_cd_o,
  output mst_snoop_req_t    snoop_req_o,
  input  mst_snoop_resp_t   snoop_resp_i,
  output domain_mask_t      domain_mask_o
);

  owner_idx_t w_arb_idx, w_gnt_idx, w_cr_head, w_cd_head, r_hold_idx;
  logic       r_hold, w_gnt_valid, w_ac_valid, w_ac_hs;
  logic       w_cr_full, w_cr_empty, w_cd_full, w_cd_empty;
  logic       w_cr_ok, w_cr_hs, w_cd_ok, w_cd_hs;

`ifdef CCU_SNOOP_ARB_FIXED_PRIO_EN
  always_comb begin
    w_arb_idx = '0;
    for (int unsigned k = NumReq; k > 0; k--) begin
      if (req_ac_valid_i[owner_idx_t'(k - 1)]) w_arb_idx = owner_idx_t'(k - 1);
    end
  end
`else
  owner_idx_t r_rr_ptr;
  logic       w_found;

  // First valid requester at or after the priority pointer
  always_comb begin
    int unsigned v_j;
    w_arb_idx = '0;
    w_found   = 1'b0;
    v_j       = 0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      v_j = (32'(r_rr_ptr) + k) % NumReq;
      if (!w_found && req_ac_valid_i[owner_idx_t'(v_j)]) begin
        w_arb_idx = owner_idx_t'(v_j);
        w_found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_rr_ptr <= '0;
    else if (w_ac_hs)
      r_rr_ptr <= (w_gnt_idx == owner_idx_t'(NumReq - 1)) ? '0 : w_gnt_idx + owner_idx_t'(1);
  end
`endif

  assign w_gnt_idx   = r_hold ? r_hold_idx : w_arb_idx;
  assign w_gnt_valid = req_ac_valid_i[w_gnt_idx];
  assign w_ac_valid  = w_gnt_valid & ~w_cr_full & ~rst_i;
  assign w_ac_hs     = w_ac_valid & snoop_resp_i.ac_ready;

  // Keep the offered AC stable until the crossbar accepts it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hold     <= 1'b0;
      r_hold_idx <= '0;
    end else begin
      r_hold     <= w_ac_valid & ~snoop_resp_i.ac_ready;
      r_hold_idx <= w_gnt_idx;
    end
  end

  assign w_cr_ok = ~rst_i & ~w_cr_empty & ~(snoop_resp_i.cr_resp.DataTransfer & w_cd_full);
  assign w_cr_hs = snoop_resp_i.cr_valid & w_cr_ok & req_cr_ready_i[w_cr_head];
  assign w_cd_ok = ~rst_i & ~w_cd_empty;
  assign w_cd_hs = snoop_resp_i.cd_valid & w_cd_ok & req_cd_ready_i[w_cd_head];

  always_comb begin
    snoop_req_o          = '0;
    snoop_req_o.ac_valid = w_ac_valid;
    snoop_req_o.ac       = req_ac_i[w_gnt_idx];
    snoop_req_o.cr_ready = w_cr_ok & req_cr_ready_i[w_cr_head];
    snoop_req_o.cd_ready = w_cd_ok & req_cd_ready_i[w_cd_head];
    domain_mask_o        = req_mask_i[w_gnt_idx];
    req_cr_o             = snoop_resp_i.cr_resp;
    req_cd_o             = snoop_resp_i.cd;
    req_ac_ready_o       = '0;
    req_cr_valid_o       = '0;
    req_cd_valid_o       = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      req_ac_ready_o[i] = w_ac_hs & (w_gnt_idx == owner_idx_t'(i));
      req_cr_valid_o[i] = snoop_resp_i.cr_valid & w_cr_ok & (w_cr_head == owner_idx_t'(i));
      req_cd_valid_o[i] = snoop_resp_i.cd_valid & w_cd_ok & (w_cd_head == owner_idx_t'(i));
    end
  end

  ccu_snoop_owner_fifo #(
    .Depth  (OwnerDepth),
    .data_t (owner_idx_t)
  ) u_cr_owner (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_ac_hs),
    .data_i  (w_gnt_idx),
    .pop_i   (w_cr_hs),
    .data_o  (w_cr_head),
    .full_o  (w_cr_full),
    .empty_o (w_cr_empty)
  );

  // CD ownership is released only on the final beat
  ccu_snoop_owner_fifo #(
    .Depth  (OwnerDepth),
    .data_t (owner_idx_t)
  ) u_cd_owner (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_cr_hs & snoop_resp_i.cr_resp.DataTransfer),
    .data_i  (w_cr_head),
    .pop_i   (w_cd_hs & snoop_resp_i.cd.last),
    .data_o  (w_cd_head),
    .full_o  (w_cd_full),
    .empty_o (w_cd_empty)
  );

endmodule

// File: tb/tb_ccu_snoop_arbiter.sv
// Directed bench for ccu_snoop_arbiter: arbitration, grant hold, queue full, CR/CD routing, reset.
module tb_ccu_snoop_arbiter;
  import ace_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       ac_valid, ac_ready_o, cr_valid_o, cr_ready, cd_valid_o, cd_ready;
  ace_ac_t          ac [2];
  ace_domain_mask_t mask [2];
  ace_cr_t          cr_o;
  ace_cd_t          cd_o;
  ace_snoop_req_t   sreq;
  ace_snoop_resp_t  sresp;
  ace_domain_mask_t dmask;
  logic [1:0]       exp_g;
  int unsigned      n_total, n_bad;

  always #5 clk = ~clk;

  ccu_snoop_arbiter dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_ac_valid_i (ac_valid),
    .req_ac_i       (ac),
    .req_ac_ready_o (ac_ready_o),
    .req_mask_i     (mask),
    .req_cr_valid_o (cr_valid_o),
    .req_cr_ready_i (cr_ready),
    .req_cr_o       (cr_o),
    .req_cd_valid_o (cd_valid_o),
    .req_cd_ready_i (cd_ready),
    .req_cd_o       (cd_o),
    .snoop_req_o    (sreq),
    .snoop_resp_i   (sresp),
    .domain_mask_o  (dmask)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst      = 1'b1;
    ac_valid = 2'b11;
    cr_ready = 2'b11;
    cd_ready = 2'b11;
    ac[0]    = '{addr: 32'h1000, snoop: 4'h1, prot: 3'h0};
    ac[1]    = '{addr: 32'h2000, snoop: 4'h7, prot: 3'h2};
    mask[0]  = 4'h3;
    mask[1]  = 4'hC;
    sresp          = '0;
    sresp.ac_ready = 1'b1;
    sresp.cr_valid = 1'b1;
    sresp.cd_valid = 1'b1;
    settle;
    chk("rst_ac_valid", 64'(sreq.ac_valid), 64'(0));
    chk("rst_ac_ready", 64'(ac_ready_o), 64'(0));
    chk("rst_cr_ready", 64'(sreq.cr_ready), 64'(0));
    chk("rst_cd_ready", 64'(sreq.cd_ready), 64'(0));
    chk("rst_cr_valid", 64'(cr_valid_o), 64'(0));
    chk("rst_cd_valid", 64'(cd_valid_o), 64'(0));
    tick;
    tick;

    // Simultaneous AC: req0 then req1
    rst = 1'b0;
    sresp.cr_valid = 1'b0;
    sresp.cd_valid = 1'b0;
    settle;
    chk("sim0_ac_valid", 64'(sreq.ac_valid), 64'(1));
    chk("sim0_gnt", 64'(ac_ready_o), 64'(2'b01));
    chk("sim0_addr", 64'(sreq.ac.addr), 64'(32'h1000));
    chk("sim0_mask", 64'(dmask), 64'(4'h3));
    tick;
    ac_valid = 2'b10;
    settle;
    chk("sim1_gnt", 64'(ac_ready_o), 64'(2'b10));
    chk("sim1_addr", 64'(sreq.ac.addr), 64'(32'h2000));
    chk("sim1_snoop", 64'(sreq.ac.snoop), 64'(4'h7));
    chk("sim1_mask", 64'(dmask), 64'(4'hC));
    tick;
    ac_valid = 2'b00;
    sresp.cr_valid = 1'b1;
    settle;
    chk("cr_order0", 64'(cr_valid_o), 64'(2'b01));
    chk("cr_order0_rdy", 64'(sreq.cr_ready), 64'(1));
    tick;
    settle;
    chk("cr_order1", 64'(cr_valid_o), 64'(2'b10));
    tick;
    settle;
    chk("cr_empty_valid", 64'(cr_valid_o), 64'(0));
    chk("cr_empty_ready", 64'(sreq.cr_ready), 64'(0));
    sresp.cr_valid = 1'b0;

    // Grant hold: req1 offered, stalled 3 cycles while req0 raises valid
    ac_valid = 2'b10;
    sresp.ac_ready = 1'b0;
    settle;
    chk("hold0_mask", 64'(dmask), 64'(4'hC));
    for (int c = 1; c < 3; c++) begin
      tick;
      ac_valid = 2'b11;
      settle;
      chk("hold_mask", 64'(dmask), 64'(4'hC));
      chk("hold_addr", 64'(sreq.ac.addr), 64'(32'h2000));
      chk("hold_ready", 64'(ac_ready_o), 64'(0));
    end
    tick;
    sresp.ac_ready = 1'b1;
    settle;
    chk("hold3_gnt", 64'(ac_ready_o), 64'(2'b10));
    chk("hold3_mask", 64'(dmask), 64'(4'hC));
    tick;
    settle;
    chk("after_hold_gnt", 64'(ac_ready_o), 64'(2'b01));
    chk("after_hold_mask", 64'(dmask), 64'(4'h3));
    tick;
    ac_valid = 2'b00;
    sresp.cr_valid = 1'b1;
    settle;
    chk("hold_cr0", 64'(cr_valid_o), 64'(2'b10));
    tick;
    settle;
    chk("hold_cr1", 64'(cr_valid_o), 64'(2'b01));
    tick;
    sresp.cr_valid = 1'b0;

    // Full CR queue blocks AC until a slot is freed
    ac_valid = 2'b01;
    for (int c = 0; c < 4; c++) begin
      settle;
      chk("fill_gnt", 64'(ac_ready_o), 64'(2'b01));
      tick;
    end
    settle;
    chk("full_ac_valid", 64'(sreq.ac_valid), 64'(0));
    chk("full_ac_ready", 64'(ac_ready_o), 64'(0));
    tick;
    sresp.cr_valid = 1'b1;
    settle;
    chk("full_pop_ac_valid", 64'(sreq.ac_valid), 64'(0));
    chk("full_pop_cr_ready", 64'(sreq.cr_ready), 64'(1));
    tick;
    sresp.cr_valid = 1'b0;
    settle;
    chk("freed_ac_valid", 64'(sreq.ac_valid), 64'(1));
    chk("freed_gnt", 64'(ac_ready_o), 64'(2'b01));
    tick;
    ac_valid = 2'b00;
    sresp.cr_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      settle;
      chk("drain_cr", 64'(cr_valid_o), 64'(2'b01));
      tick;
    end
    sresp.cr_valid = 1'b0;

    // CR with data for owner 1, then a 4-beat CD
    ac_valid = 2'b10;
    settle;
    chk("cd_ac_gnt", 64'(ac_ready_o), 64'(2'b10));
    tick;
    ac_valid = 2'b00;
    sresp.cr_valid = 1'b1;
    sresp.cr_resp.DataTransfer = 1'b1;
    settle;
    chk("cd_cr_valid", 64'(cr_valid_o), 64'(2'b10));
    chk("cd_cr_ready", 64'(sreq.cr_ready), 64'(1));
    chk("cd_cr_payload", 64'(cr_o), 64'(5'b00001));
    tick;
    sresp.cr_valid = 1'b0;
    sresp.cr_resp  = '0;
    sresp.cd_valid = 1'b1;
    for (int b = 0; b < 4; b++) begin
      sresp.cd.data = DataWidth'(64'hA0 + 64'(b));
      sresp.cd.last = (b == 3);
      settle;
      chk("cd_beat_valid", 64'(cd_valid_o), 64'(2'b10));
      chk("cd_beat_ready", 64'(sreq.cd_ready), 64'(1));
      chk("cd_beat_data", 64'(cd_o.data), 64'hA0 + 64'(b));
      tick;
    end
    sresp.cd.last = 1'b0;
    settle;
    chk("cd_popped_ready", 64'(sreq.cd_ready), 64'(0));
    chk("cd_popped_valid", 64'(cd_valid_o), 64'(0));
    sresp.cd_valid = 1'b0;
    tick;

    // CR without data leaves the CD queue empty
    ac_valid = 2'b01;
    settle;
    chk("nodt_ac_gnt", 64'(ac_ready_o), 64'(2'b01));
    tick;
    ac_valid = 2'b00;
    sresp.cr_valid = 1'b1;
    settle;
    chk("nodt_cr_ready", 64'(sreq.cr_ready), 64'(1));
    chk("nodt_cr_valid", 64'(cr_valid_o), 64'(2'b01));
    tick;
    sresp.cr_valid = 1'b0;
    sresp.cd_valid = 1'b1;
    sresp.cd.last  = 1'b1;
    settle;
    chk("nodt_cd_ready", 64'(sreq.cd_ready), 64'(0));
    chk("nodt_cd_valid", 64'(cd_valid_o), 64'(0));
    sresp.cd_valid = 1'b0;
    sresp.cd.last  = 1'b0;
    tick;

    // Reset in the middle of a CD burst
    ac_valid = 2'b10;
    settle;
    chk("mid_ac1", 64'(ac_ready_o), 64'(2'b10));
    tick;
    ac_valid = 2'b01;
    settle;
    chk("mid_ac0", 64'(ac_ready_o), 64'(2'b01));
    tick;
    ac_valid = 2'b00;
    sresp.cr_valid = 1'b1;
    sresp.cr_resp.DataTransfer = 1'b1;
    settle;
    chk("mid_cr", 64'(cr_valid_o), 64'(2'b10));
    tick;
    sresp.cr_valid = 1'b0;
    sresp.cr_resp  = '0;
    sresp.cd_valid = 1'b1;
    for (int b = 0; b < 2; b++) begin
      settle;
      chk("mid_cd_beat", 64'(cd_valid_o), 64'(2'b10));
      tick;
    end
    rst = 1'b1;
    sresp.cr_valid = 1'b1;
    settle;
    chk("in_rst_cd_ready", 64'(sreq.cd_ready), 64'(0));
    chk("in_rst_cr_ready", 64'(sreq.cr_ready), 64'(0));
    chk("in_rst_cd_valid", 64'(cd_valid_o), 64'(0));
    tick;
    rst = 1'b0;
    settle;
    chk("post_rst_cd_ready", 64'(sreq.cd_ready), 64'(0));
    chk("post_rst_cr_ready", 64'(sreq.cr_ready), 64'(0));
    chk("post_rst_cd_valid", 64'(cd_valid_o), 64'(0));
    chk("post_rst_cr_valid", 64'(cr_valid_o), 64'(0));
    sresp.cr_valid = 1'b0;
    sresp.cd_valid = 1'b0;

    // Repeated simultaneous AC after reset
    ac_valid = 2'b11;
    for (int c = 0; c < 3; c++) begin
`ifdef CCU_SNOOP_ARB_FIXED_PRIO_EN
      exp_g = 2'b01;
`else
      exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
`endif
      settle;
      chk("repeat_gnt", 64'(ac_ready_o), 64'(exp_g));
      tick;
    end
    ac_valid = 2'b00;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
